// File: rtl/plru_array_if.sv
// Request/response bundle for plru_array: hit updates, victim queries, flush and registered victim result.
interface plru_array_if #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic                touch_valid;
  logic [SET_W-1:0]    touch_set;
  logic [WAY_W-1:0]    touch_way;
  logic                victim_req;
  logic [SET_W-1:0]    victim_set;
  logic [NUM_WAYS-1:0] victim_valid_mask;
  logic                victim_alloc;
  logic                flush;
  logic                victim_out_valid;
  logic [WAY_W-1:0]    victim_way;
  logic                victim_was_invalid;

  modport master (
    output touch_valid, touch_set, touch_way,
    output victim_req, victim_set, victim_valid_mask, victim_alloc,
    output flush,
    input  victim_out_valid, victim_way, victim_was_invalid
  );

  modport slave (
    input  touch_valid, touch_set, touch_way,
    input  victim_req, victim_set, victim_valid_mask, victim_alloc,
    input  flush,
    output victim_out_valid, victim_way, victim_was_invalid
  );
endinterface

// File: rtl/plru_array.sv
// Tree pseudo-LRU replacement state for a set-associative array; one heap-ordered tree per set
// with a registered victim lookup that prefers invalid ways.
module plru_array #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4
) (
  input  logic        clk,
  input  logic        rst,
  plru_array_if.slave bus
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int NODES = NUM_WAYS - 1;
  localparam int EXT_W = 2 * NUM_WAYS;

  logic [NUM_SETS-1:0][NODES-1:0] tree_q, tree_d;
  logic                           victim_out_valid_q, victim_out_valid_d;
  logic [WAY_W-1:0]               victim_way_q, victim_way_d;
  logic                           victim_was_invalid_q, victim_was_invalid_d;

  logic [NODES-1:0]               query_bits;
  logic [WAY_W-1:0]               tree_way;
  logic [WAY_W-1:0]               inv_way;
  logic                           any_invalid;

  // Bits are padded to a power-of-two width so the node index needs no truncation.
  // The chosen directions, MSB first, spell out the leaf (way) index.
  function automatic logic [WAY_W-1:0] walk_victim(input logic [NODES-1:0] bits);
    logic [EXT_W-1:0] ext;
    logic [WAY_W:0]   node;
    logic [WAY_W-1:0] way;
    ext  = EXT_W'(bits);
    node = '0;
    way  = '0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      way  = {way[WAY_W-2+1-1:0], ext[node]} ;
      node = (node << 1) + (WAY_W+1)'(1) + (WAY_W+1)'(ext[node]);
    end
    return way;
  endfunction

  function automatic logic [NODES-1:0] mark_mru(input logic [NODES-1:0] bits,
                                                input logic [WAY_W-1:0] way);
    logic [EXT_W-1:0] ext;
    logic [WAY_W:0]   node;
    logic [WAY_W-1:0] w;
    logic             dir;
    ext  = EXT_W'(bits);
    node = '0;
    w    = way;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      dir       = w[WAY_W-1];
      ext[node] = ~dir;
      node      = (node << 1) + (WAY_W+1)'(1) + (WAY_W+1)'(dir);
      w         = w << 1;
    end
    return ext[NODES-1:0];
  endfunction

  always_comb begin
    query_bits  = tree_q[bus.victim_set];
    tree_way    = walk_victim(query_bits);
    any_invalid = 1'b0;
    inv_way     = '0;
    for (int unsigned w = NUM_WAYS; w > 0; w--) begin
      if (!bus.victim_valid_mask[w-1]) begin
        any_invalid = 1'b1;
        inv_way     = WAY_W'(w-1);
      end
    end
  end

  always_comb begin
    victim_out_valid_d   = bus.victim_req;
    victim_way_d         = '0;
    victim_was_invalid_d = 1'b0;
    if (bus.victim_req) begin
      victim_way_d         = any_invalid ? inv_way : tree_way;
      victim_was_invalid_d = any_invalid;
    end
  end

  // Touch first, then alloc on top of it, so alloc wins any node both paths share.
  always_comb begin
    tree_d = tree_q;
    if (bus.touch_valid)
      tree_d[bus.touch_set] = mark_mru(tree_d[bus.touch_set], bus.touch_way);
    if (bus.victim_req && bus.victim_alloc)
      tree_d[bus.victim_set] = mark_mru(tree_d[bus.victim_set], victim_way_d);
    if (bus.flush)
      tree_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_q               <= '0;
      victim_out_valid_q   <= 1'b0;
      victim_way_q         <= '0;
      victim_was_invalid_q <= 1'b0;
    end else begin
      tree_q               <= tree_d;
      victim_out_valid_q   <= victim_out_valid_d;
      victim_way_q         <= victim_way_d;
      victim_was_invalid_q <= victim_was_invalid_d;
    end
  end

  assign bus.victim_out_valid   = victim_out_valid_q;
  assign bus.victim_way         = victim_way_q;
  assign bus.victim_was_invalid = victim_was_invalid_q;
endmodule

// File: tb/tb_plru_array.sv
// Directed bench for plru_array (16 sets, 4 ways) with hand-derived victim expectations.
module tb_plru_array;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  plru_array_if #(.NUM_SETS(16), .NUM_WAYS(4)) ifc ();

  plru_array #(.NUM_SETS(16), .NUM_WAYS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    ifc.touch_valid       = 1'b0;
    ifc.touch_set         = '0;
    ifc.touch_way         = '0;
    ifc.victim_req        = 1'b0;
    ifc.victim_set        = '0;
    ifc.victim_valid_mask = '0;
    ifc.victim_alloc      = 1'b0;
    ifc.flush             = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic touch(input logic [3:0] set, input logic [1:0] way);
    ifc.touch_valid = 1'b1;
    ifc.touch_set   = set;
    ifc.touch_way   = way;
    step();
    idle_inputs();
  endtask

  task automatic query(input string tag, input logic [3:0] set, input logic [3:0] mask,
                       input logic alloc, input logic [1:0] exp_way, input logic exp_inv);
    ifc.victim_req        = 1'b1;
    ifc.victim_set        = set;
    ifc.victim_valid_mask = mask;
    ifc.victim_alloc      = alloc;
    step();
    idle_inputs();
    check({tag, "_valid"}, 32'(ifc.victim_out_valid), 32'd1);
    check({tag, "_way"}, 32'(ifc.victim_way), 32'(exp_way));
    check({tag, "_inv"}, 32'(ifc.victim_was_invalid), 32'(exp_inv));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    idle_inputs();
    #2;
    check("rst_valid", 32'(ifc.victim_out_valid), 32'd0);
    check("rst_way", 32'(ifc.victim_way), 32'd0);
    do_reset();

    query("reset_q", 4'd0, 4'b1111, 1'b0, 2'd0, 1'b0);
    step();
    check("no_req_valid", 32'(ifc.victim_out_valid), 32'd0);

    // Mask/alloc must be ignored without victim_req
    ifc.victim_set = 4'd0; ifc.victim_valid_mask = 4'b0000; ifc.victim_alloc = 1'b1;
    step();
    idle_inputs();
    check("ignored_req_valid", 32'(ifc.victim_out_valid), 32'd0);
    query("ignored_alloc", 4'd0, 4'b1111, 1'b0, 2'd0, 1'b0);

    for (int w = 0; w < 4; w++) touch(4'd5, 2'(w));
    query("seq_touch", 4'd5, 4'b1111, 1'b0, 2'd0, 1'b0);
    touch(4'd6, 2'd0);
    query("touch0", 4'd6, 4'b1111, 1'b0, 2'd2, 1'b0);

    query("invalid", 4'd2, 4'b1011, 1'b0, 2'd2, 1'b1);
    query("invalid_nochg", 4'd2, 4'b1111, 1'b0, 2'd0, 1'b0);
    query("invalid_low", 4'd2, 4'b0110, 1'b0, 2'd0, 1'b1);

    do_reset();
    query("alloc1", 4'd3, 4'b1111, 1'b1, 2'd0, 1'b0);
    query("alloc2", 4'd3, 4'b1111, 1'b1, 2'd2, 1'b0);
    query("alloc3", 4'd3, 4'b1111, 1'b1, 2'd1, 1'b0);

    do_reset();
    ifc.touch_valid = 1'b1; ifc.touch_set = 4'd0; ifc.touch_way = 2'd0;
    query("same_cycle", 4'd0, 4'b1111, 1'b0, 2'd0, 1'b0);
    query("after_touch", 4'd0, 4'b1111, 1'b0, 2'd2, 1'b0);

    // Set 7: touch 3, then touch 1 with alloc (victim 0) together; alloc sets node1 = 1
    touch(4'd7, 2'd3);
    ifc.touch_valid = 1'b1; ifc.touch_set = 4'd7; ifc.touch_way = 2'd1;
    query("alloc_touch", 4'd7, 4'b1111, 1'b1, 2'd0, 1'b0);
    touch(4'd7, 2'd2);
    query("alloc_wins", 4'd7, 4'b1111, 1'b0, 2'd1, 1'b0);

    touch(4'd8, 2'd0);
    touch(4'd9, 2'd1);
    ifc.flush = 1'b1; ifc.touch_valid = 1'b1; ifc.touch_set = 4'd10; ifc.touch_way = 2'd0;
    step();
    idle_inputs();
    query("flush8", 4'd8, 4'b1111, 1'b0, 2'd0, 1'b0);
    query("flush9", 4'd9, 4'b1111, 1'b0, 2'd0, 1'b0);
    query("flush10", 4'd10, 4'b1111, 1'b0, 2'd0, 1'b0);

    touch(4'd11, 2'd0);
    ifc.victim_req = 1'b1; ifc.victim_set = 4'd11; ifc.victim_valid_mask = 4'b1111;
    step();
    idle_inputs();
    check("pre_async_valid", 32'(ifc.victim_out_valid), 32'd1);
    check("pre_async_way", 32'(ifc.victim_way), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(ifc.victim_out_valid), 32'd0);
    check("async_way", 32'(ifc.victim_way), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_valid", 32'(ifc.victim_out_valid), 32'd0);
    query("post_rst_tree", 4'd11, 4'b1111, 1'b0, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/plru_array.md
PLRU_ARRAY -- requirements
Module: plru_array

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16: number of sets; power of two, >= 2.
REQ-002 SHALL have parameter NUM_WAYS, default 4: ways per set; power of two, >= 2.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port touch_valid  input  1: hit-update request this cycle.
REQ-006 SHALL have port touch_set  input  $clog2(NUM_SETS): set index of the hit.
REQ-007 SHALL have port touch_way  input  $clog2(NUM_WAYS): way that hit.
REQ-008 SHALL have port victim_req  input  1: victim query this cycle.
REQ-009 SHALL have port victim_set  input  $clog2(NUM_SETS): set being queried.
REQ-010 SHALL have port victim_valid_mask  input  NUM_WAYS: bit w = 1 means way w holds valid data.
REQ-011 SHALL have port victim_alloc  input  1: with victim_req, also mark the chosen victim as MRU.
REQ-012 SHALL have port flush  input  1: clear PLRU state of every set.
REQ-013 SHALL have port victim_out_valid  output  1: victim_way is valid this cycle.
REQ-014 SHALL have port victim_way  output  $clog2(NUM_WAYS): selected victim.
REQ-015 SHALL have port victim_was_invalid  output  1: victim chosen because its way was invalid.

Function
REQ-016 SHALL hold NUM_WAYS-1 tree bits per set, heap-indexed: node 0 = root, children of node i = 2i+1 (left), 2i+2 (right); leaves map to ways 0..NUM_WAYS-1 left to right.
REQ-017 SHALL interpret a tree bit of 0 as "LRU side is left", 1 as "LRU side is right".
REQ-018 SHALL compute the tree victim by walking from the root, following each node's bit, to a leaf.
REQ-019 SHALL, on touch of way w, set every node on w's root-to-leaf path to point away from w (bit = 1 if w lies in left subtree, 0 if in right); nodes off the path are unchanged.
REQ-020 SHALL select as victim the lowest-index way with victim_valid_mask bit 0, setting victim_was_invalid = 1; if the mask is all ones, SHALL select the tree victim with victim_was_invalid = 0.
REQ-021 SHALL register the victim: request sampled at edge t produces victim_out_valid = 1 with victim_way/victim_was_invalid during the cycle after edge t; victim_out_valid = 0 in cycles following no request.
REQ-022 SHALL compute the victim from state as it stood before edge t (same-cycle touch, alloc or flush does not affect that result).
REQ-023 SHALL, when victim_req and victim_alloc are both 1, apply a touch of the selected victim to victim_set at edge t.
REQ-024 SHALL, when touch and alloc hit the same set in one cycle, apply the touch first, then the alloc path bits, so alloc wins on shared nodes; different sets update independently.
REQ-025 SHALL, when flush = 1, clear all tree bits of all sets to 0 at the edge, overriding same-cycle touch and alloc updates.
REQ-026 SHALL accept touch and victim query every cycle with no stalls and no back-pressure.
REQ-027 SHALL ignore touch_set/touch_way when touch_valid = 0, and victim_set/mask/alloc when victim_req = 0.

Reset
REQ-028 SHALL, while rst = 1, immediately and asynchronously clear all tree bits to 0 and drive victim_out_valid, victim_way and victim_was_invalid to 0.
REQ-029 SHALL drop any in-flight victim result when rst asserts mid-operation; first valid result after release requires a new request.

Verification (NUM_SETS = 16, NUM_WAYS = 4)
REQ-030 Reset, query set 0 with mask 4'b1111 -> next cycle victim_out_valid = 1, victim_way = 0, victim_was_invalid = 0.
REQ-031 Touch set 5 ways 0,1,2,3 on consecutive cycles, then query with mask 4'b1111 -> victim_way = 0; touch 0 alone from reset -> victim_way = 2.
REQ-032 Query set 2 with mask 4'b1011 -> victim_way = 2, victim_was_invalid = 1; tree state of set 2 unchanged (no alloc).
REQ-033 Reset, query set 3 with alloc and mask 4'b1111 -> victim_way = 0; repeat query with alloc -> victim_way = 2; third -> 1.
REQ-034 Reset, touch set 0 way 0 and query set 0 in the same cycle -> victim_way = 0; following query -> victim_way = 2.
REQ-035 Touch several sets, assert flush together with a touch, then query each -> victim_way = 0; assert rst between edges -> victim_out_valid falls to 0 without waiting for a clock edge.
